// File: rtl/flu_length_meter_pkg.sv
// Shared constants and helpers for the FLU frame length meter.
package flu_length_meter_pkg;

    // Default configuration of the meter.
    localparam int DATA_WIDTH_DEF    = 256;
    localparam int SOP_POS_WIDTH_DEF = 2;
    localparam int LENGTH_WIDTH_DEF  = 16;
    localparam int FIFO_ITEMS_DEF    = 16;

    // Derived constants for the default configuration.
    localparam int BYTES          = DATA_WIDTH_DEF / 8;
    localparam int BLOCK          = BYTES / (2 ** SOP_POS_WIDTH_DEF);
    localparam int EOP_POS_WIDTH  = $clog2(BYTES);
    localparam int FIFO_PTR_WIDTH = $clog2(FIFO_ITEMS_DEF);

    // Add two lengths and clamp the result at max instead of wrapping.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max}) ? max : sum[31:0];
    endfunction

endpackage

// File: rtl/flu_length_meter_fifo.sv
// Register FIFO holding measured frame lengths; full is a registered flag.
module flu_length_meter_fifo #(
    parameter int WIDTH = 16,
    parameter int ITEMS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(ITEMS);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [ITEMS];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             full_q;

    // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (!push && pop) begin
            count_nxt = count - 1'b1;
        end
    end

    // Storage array; written only on push.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; validity is tracked by count, so clearing it would only add reset fan-out.
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and registered full flag; pointers wrap naturally.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count  <= count_nxt;
            full_q <= (count_nxt == CNT_W'(ITEMS));
        end
    end

    assign full  = full_q;
    assign empty = (count == '0);
    assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/flu_length_meter.sv
// FLU pass-through that measures the byte length of each completed frame
// and queues the lengths for the LENGTH / LENGTH_READY / LENGTH_NEXT interface.
module flu_length_meter
    import flu_length_meter_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int SOP_POS_WIDTH = SOP_POS_WIDTH_DEF,
    parameter int LENGTH_WIDTH  = LENGTH_WIDTH_DEF,
    parameter int FIFO_ITEMS    = FIFO_ITEMS_DEF
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic [DATA_WIDTH-1:0]           RX_DATA,
    input  logic [SOP_POS_WIDTH-1:0]        RX_SOP_POS,
    input  logic [$clog2(DATA_WIDTH/8)-1:0] RX_EOP_POS,
    input  logic                            RX_SOP,
    input  logic                            RX_EOP,
    input  logic                            RX_SRC_RDY,
    output logic                            RX_DST_RDY,
    output logic [DATA_WIDTH-1:0]           TX_DATA,
    output logic [SOP_POS_WIDTH-1:0]        TX_SOP_POS,
    output logic [$clog2(DATA_WIDTH/8)-1:0] TX_EOP_POS,
    output logic                            TX_SOP,
    output logic                            TX_EOP,
    output logic                            TX_SRC_RDY,
    input  logic                            TX_DST_RDY,
    output logic [LENGTH_WIDTH-1:0]         LENGTH,
    output logic                            LENGTH_READY,
    input  logic                            LENGTH_NEXT
);

    localparam int          WORD_BYTES  = DATA_WIDTH / 8;
    localparam int          BLOCK_BYTES = WORD_BYTES >> SOP_POS_WIDTH;
    localparam logic [31:0] LEN_MAX     = 32'((longint'(1) << LENGTH_WIDTH) - 1);

    logic                    xfer;
    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;
    logic [LENGTH_WIDTH-1:0] push_len;
    logic                    in_frame;
    logic                    in_frame_nxt;
    logic [LENGTH_WIDTH-1:0] acc;
    logic [LENGTH_WIDTH-1:0] acc_nxt;
    logic [31:0]             sop_byte;
    logic [31:0]             eop_pos;
    logic                    single_word;

    // Combinational pass-through; the whole stream stalls while the length FIFO is full.
    assign TX_DATA    = RX_DATA;
    assign TX_SOP_POS = RX_SOP_POS;
    assign TX_EOP_POS = RX_EOP_POS;
    assign TX_SOP     = RX_SOP;
    assign TX_EOP     = RX_EOP;
    assign TX_SRC_RDY = RX_SRC_RDY && !full;
    assign RX_DST_RDY = TX_DST_RDY && !full;

    assign xfer        = RX_SRC_RDY && RX_DST_RDY;
    assign sop_byte    = 32'(RX_SOP_POS) * 32'(BLOCK_BYTES);
    assign eop_pos     = 32'(RX_EOP_POS);
    // SOP at or before the EOP byte means the word holds a whole frame;
    // otherwise the EOP closes the old frame and the SOP opens a new one.
    assign single_word = RX_SOP && RX_EOP && (sop_byte <= eop_pos);

    // Frame tracking: accumulate word bytes and emit a length on each closing EOP.
    always_comb begin
        acc_nxt      = acc;
        in_frame_nxt = in_frame;
        push         = 1'b0;
        push_len     = '0;
        if (xfer) begin
            if (single_word) begin
                push         = 1'b1;
                push_len     = LENGTH_WIDTH'(sat_add(eop_pos - sop_byte, 32'd1, LEN_MAX));
                in_frame_nxt = 1'b0;
            end else begin
                if (RX_EOP) begin
                    // An EOP with no open frame is an orphan tail and is dropped.
                    if (in_frame) begin
                        push     = 1'b1;
                        push_len = LENGTH_WIDTH'(sat_add(32'(acc), eop_pos + 32'd1, LEN_MAX));
                    end
                    in_frame_nxt = 1'b0;
                end
                if (RX_SOP) begin
                    // A SOP inside an open frame silently restarts the count.
                    acc_nxt      = LENGTH_WIDTH'(sat_add(32'(WORD_BYTES) - sop_byte, 32'd0, LEN_MAX));
                    in_frame_nxt = 1'b1;
                end else if (!RX_EOP && in_frame) begin
                    acc_nxt = LENGTH_WIDTH'(sat_add(32'(acc), 32'(WORD_BYTES), LEN_MAX));
                end
            end
        end
    end

    // Frame tracking state; a frame open at reset is discarded.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            in_frame <= 1'b0;
            acc      <= '0;
        end else begin
            in_frame <= in_frame_nxt;
            acc      <= acc_nxt;
        end
    end

    assign pop          = LENGTH_NEXT && !empty;
    assign LENGTH_READY = !empty;

    flu_length_meter_fifo #(
        .WIDTH (LENGTH_WIDTH),
        .ITEMS (FIFO_ITEMS)
    ) u_fifo (
        .clk   (CLK),
        .reset (RESET),
        .push  (push),
        .din   (push_len),
        .pop   (pop),
        .dout  (LENGTH),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_flu_length_meter.sv
// Self-checking bench for flu_length_meter: directed steps plus random traffic
// against a queue-based frame length model.
module tb_flu_length_meter;

    localparam int ITEMS   = 16;
    localparam int WBYTES  = 32;
    localparam int BLK     = WBYTES / 4;
    localparam int MAX16   = 65535;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] rx_data;
    logic [1:0]   rx_sop_pos;
    logic [4:0]   rx_eop_pos;
    logic         rx_sop, rx_eop, rx_src_rdy, tx_dst_rdy, length_next;
    logic         rx_dst_rdy;
    logic [255:0] tx_data;
    logic [1:0]   tx_sop_pos;
    logic [4:0]   tx_eop_pos;
    logic         tx_sop, tx_eop, tx_src_rdy;
    logic [15:0]  length;
    logic         length_ready;

    // Second instance with a 6-bit length for saturation checks.
    logic         rx_src_rdy6, length_next6;
    logic         rx_dst_rdy6;
    logic [255:0] tx_data6;
    logic [1:0]   tx_sop_pos6;
    logic [4:0]   tx_eop_pos6;
    logic         tx_sop6, tx_eop6, tx_src_rdy6;
    logic [5:0]   length6;
    logic         length_ready6;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    int exp_q[$];
    int m_acc;
    bit m_in;

    always #5 clk = ~clk;

    flu_length_meter dut (
        .CLK(clk), .RESET(reset),
        .RX_DATA(rx_data), .RX_SOP_POS(rx_sop_pos), .RX_EOP_POS(rx_eop_pos),
        .RX_SOP(rx_sop), .RX_EOP(rx_eop), .RX_SRC_RDY(rx_src_rdy), .RX_DST_RDY(rx_dst_rdy),
        .TX_DATA(tx_data), .TX_SOP_POS(tx_sop_pos), .TX_EOP_POS(tx_eop_pos),
        .TX_SOP(tx_sop), .TX_EOP(tx_eop), .TX_SRC_RDY(tx_src_rdy), .TX_DST_RDY(tx_dst_rdy),
        .LENGTH(length), .LENGTH_READY(length_ready), .LENGTH_NEXT(length_next)
    );

    flu_length_meter #(.LENGTH_WIDTH(6)) dut6 (
        .CLK(clk), .RESET(reset),
        .RX_DATA(rx_data), .RX_SOP_POS(rx_sop_pos), .RX_EOP_POS(rx_eop_pos),
        .RX_SOP(rx_sop), .RX_EOP(rx_eop), .RX_SRC_RDY(rx_src_rdy6), .RX_DST_RDY(rx_dst_rdy6),
        .TX_DATA(tx_data6), .TX_SOP_POS(tx_sop_pos6), .TX_EOP_POS(tx_eop_pos6),
        .TX_SOP(tx_sop6), .TX_EOP(tx_eop6), .TX_SRC_RDY(tx_src_rdy6), .TX_DST_RDY(tx_dst_rdy),
        .LENGTH(length6), .LENGTH_READY(length_ready6), .LENGTH_NEXT(length_next6)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sop, input bit eop, input int sp, input int ep, input bit src);
        rx_sop     = sop;
        rx_eop     = eop;
        rx_sop_pos = 2'(sp);
        rx_eop_pos = 5'(ep);
        rx_src_rdy = src;
        rx_data    = {$urandom(), $urandom(), $urandom(), $urandom(),
                      $urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    function automatic int clamp(input int v);
        return (v > MAX16) ? MAX16 : v;
    endfunction

    // Called at posedge+1: wait to mid-cycle and compare all outputs with the model.
    task automatic step_check();
        bit mfull;
        #4;
        mfull = (exp_q.size() == ITEMS);
        check("tx_data",    tx_data,    rx_data);
        check("tx_sop_pos", tx_sop_pos, rx_sop_pos);
        check("tx_eop_pos", tx_eop_pos, rx_eop_pos);
        check("tx_sop",     tx_sop,     rx_sop);
        check("tx_eop",     tx_eop,     rx_eop);
        check("tx_src_rdy", tx_src_rdy, rx_src_rdy && !mfull);
        check("rx_dst_rdy", rx_dst_rdy, tx_dst_rdy && !mfull);
        check("length_ready", length_ready, exp_q.size() > 0);
        check("length", length, (exp_q.size() > 0) ? exp_q[0] : 0);
    endtask

    // Apply this cycle's transfer to the model, then advance to posedge+1.
    task automatic step_finish();
        bit mfull, xfer;
        int sb, ep;
        mfull = (exp_q.size() == ITEMS);
        xfer  = rx_src_rdy && tx_dst_rdy && !mfull;
        sb    = int'(rx_sop_pos) * BLK;
        ep    = int'(rx_eop_pos);
        if (length_next && exp_q.size() > 0) void'(exp_q.pop_front());
        if (xfer) begin
            if (rx_sop && rx_eop && sb <= ep) begin
                exp_q.push_back(clamp(ep - sb + 1));
                m_in = 1'b0;
            end else begin
                if (rx_eop) begin
                    if (m_in) exp_q.push_back(clamp(m_acc + ep + 1));
                    m_in = 1'b0;
                end
                if (rx_sop) begin
                    m_acc = WBYTES - sb;
                    m_in  = 1'b1;
                end else if (!rx_eop && m_in) begin
                    m_acc = clamp(m_acc + WBYTES);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        step_check();
        step_finish();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        m_acc = 0;
        m_in  = 1'b0;
        #1;
        check("rst_length_ready", length_ready, 1'b0);
        check("rst_length", length, 16'd0);
        check("rst_rx_dst_rdy", rx_dst_rdy, tx_dst_rdy);
        check("rst_length_ready6", length_ready6, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // Pop until the model is empty, bounded in cycles.
    task automatic drain();
        idle();
        length_next = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) step();
        length_next = 1'b0;
        step_check();
        check("drain_empty", length_ready, 1'b0);
        step_finish();
    endtask

    initial begin
        reset        = 1'b1;
        tx_dst_rdy   = 1'b1;
        length_next  = 1'b0;
        rx_src_rdy6  = 1'b0;
        length_next6 = 1'b0;
        idle();
        m_acc = 0;
        m_in  = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Single-word frame: SOP block 1, EOP byte 20 -> 13 bytes.
        drive(1, 1, 1, 20, 1);
        step();
        idle();
        check("t1_ready", length_ready, 1'b1);
        check("t1_len", length, 16'd13);
        step();
        drain();

        // Three-word frame: 32 + 32 + 6 = 70.
        drive(1, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 1);
        step();
        drive(0, 1, 0, 5, 1);
        step();
        idle();
        check("t2_len", length, 16'd70);
        drain();

        // EOP closes a frame and a later SOP in the same word opens the next.
        drive(1, 0, 0, 0, 1);
        step();
        drive(1, 1, 2, 3, 1);
        step();
        check("t3_first", length, 16'd36);
        drive(0, 1, 0, 31, 1);
        step();
        idle();
        length_next = 1'b1;
        step();
        length_next = 1'b0;
        check("t3_second", length, 16'd48);
        drain();

        // Fill the FIFO and verify the stream stalls until a pop.
        tx_dst_rdy = 1'b1;
        for (int i = 0; i < ITEMS; i++) begin
            drive(1, 1, 0, i, 1);
            step();
        end
        drive(1, 1, 0, 16, 1);
        step_check();
        check("t4_rx_dst_rdy_full", rx_dst_rdy, 1'b0);
        check("t4_tx_src_rdy_full", tx_src_rdy, 1'b0);
        step_finish();
        length_next = 1'b1;
        step_check();
        check("t4_first_pop", length, 16'd1);
        step_finish();
        length_next = 1'b0;
        step_check();
        check("t4_rx_dst_rdy_after_pop", rx_dst_rdy, 1'b1);
        step_finish();
        drain();

        // Reset mid-frame: the tail becomes an orphan and pushes nothing.
        drive(1, 0, 0, 0, 1);
        step();
        do_reset();
        drive(0, 1, 0, 9, 1);
        step();
        idle();
        step_check();
        check("t5_orphan_ready", length_ready, 1'b0);
        step_finish();
        drive(1, 1, 0, 31, 1);
        step();
        idle();
        check("t5_len", length, 16'd32);
        drain();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            tx_dst_rdy  = ($urandom_range(0, 3) != 0);
            length_next = ($urandom_range(0, 9) < 3);
            drive($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
                  $urandom_range(0, 3), $urandom_range(0, 31),
                  $urandom_range(0, 3) != 0);
            step();
        end
        tx_dst_rdy = 1'b1;
        drain();

        // Saturation on the 6-bit instance: 128-byte frame reports 63.
        rx_src_rdy6 = 1'b1;
        drive(1, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        drive(0, 1, 0, 31, 0);
        step();
        rx_src_rdy6 = 1'b0;
        idle();
        check("t6_ready", length_ready6, 1'b1);
        check("t6_len_sat", length6, 6'd63);
        length_next6 = 1'b1;
        step();
        length_next6 = 1'b0;
        check("t6_popped_ready", length_ready6, 1'b0);
        check("t6_popped_len", length6, 6'd0);
        length_next6 = 1'b1;
        step();
        length_next6 = 1'b0;
        check("t6_empty_pop_ready", length_ready6, 1'b0);
        check("t6_empty_pop_len", length6, 6'd0);
        check("t6_dst_rdy", rx_dst_rdy6, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flu_length_meter.md
Name: flu_length_meter

Overview:
- Sits directly downstream of the FLU trimming unit.
- Forwards the FLU stream unchanged and measures the byte length of every completed frame.
- Queues each length in a small FIFO exposed through the team's length interface (LENGTH / LENGTH_READY / LENGTH_NEXT).
- Used for per-frame statistics and as a checker of trimmed output lengths.

Parameters:
- DATA_WIDTH, 256: FLU data width in bits; DATA_WIDTH/8 = BYTES per word.
- SOP_POS_WIDTH, 2: SOP position width; block size BLOCK = BYTES / 2**SOP_POS_WIDTH bytes.
- LENGTH_WIDTH, 16: width of the reported length.
- FIFO_ITEMS, 16: length FIFO depth; power of two, at least 2.

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset.
- RX_DATA  in  DATA_WIDTH  FLU data.
- RX_SOP_POS  in  SOP_POS_WIDTH  SOP block index.
- RX_EOP_POS  in  log2(BYTES)  byte index of last byte.
- RX_SOP  in  1  start of packet.
- RX_EOP  in  1  end of packet.
- RX_SRC_RDY  in  1  source ready.
- RX_DST_RDY  out  1  destination ready.
- TX_DATA, TX_SOP_POS, TX_EOP_POS, TX_SOP, TX_EOP  out  as RX  forwarded FLU word.
- TX_SRC_RDY  out  1  source ready.
- TX_DST_RDY  in  1  destination ready.
- LENGTH  out  LENGTH_WIDTH  head-of-FIFO frame length in bytes.
- LENGTH_READY  out  1  LENGTH valid.
- LENGTH_NEXT  in  1  pop head of FIFO.

Behaviour:
- Interface: single clock CLK; RESET is synchronous and active-high.
- Datapath pass-through is combinational:
  - TX_DATA/POS/SOP/EOP = RX.
  - TX_SRC_RDY = RX_SRC_RDY and not full.
  - RX_DST_RDY = TX_DST_RDY and not full.
- Transfer: xfer = RX_SRC_RDY and RX_DST_RDY. All state changes occur only on xfer; at most one EOP per word, so at most one push per cycle.
- Definitions:
  - sop_byte = RX_SOP_POS*BLOCK.
  - A word with SOP and EOP is a single-word frame if sop_byte <= RX_EOP_POS.
  - Otherwise the EOP closes the previous frame and the SOP opens a new one.
- State: in_frame flag and acc accumulator (LENGTH_WIDTH bits, saturating at 2**LENGTH_WIDTH-1).
- Cases on xfer:
  - No SOP, no EOP, in_frame: acc += BYTES.
  - No SOP, no EOP, not in_frame: ignored.
  - SOP only: acc = BYTES - sop_byte; in_frame = 1. A SOP while in_frame (missing EOP) silently restarts the frame; no push.
  - EOP only, in_frame: push acc + RX_EOP_POS + 1; in_frame = 0.
  - EOP only, not in_frame: no push (orphan tail).
  - Single-word frame: push RX_EOP_POS - sop_byte + 1; in_frame = 0.
  - EOP then SOP in the same word: push per the EOP-only rule; then acc = BYTES - sop_byte; in_frame = 1.
- Saturation: every addition saturates; the pushed value saturates too.
- FIFO:
  - A pushed length is visible on LENGTH with LENGTH_READY=1 in the cycle after the push (latency 1). No bypass.
  - Pop on LENGTH_NEXT and LENGTH_READY; LENGTH_NEXT while empty is ignored.
  - full is registered: count == FIFO_ITEMS.
  - Simultaneous push and pop allowed when not full; count unchanged.
  - When full, RX/TX are stalled even if the current word carries no EOP. A pop while full clears full in the next cycle.
  - Pointers wrap modulo FIFO_ITEMS.
- Reset values:
  - in_frame = 0, acc = 0, FIFO empty.
  - LENGTH_READY = 0; LENGTH = 0 while empty.
  - RX_DST_RDY follows TX_DST_RDY.
  - A frame in progress at reset is discarded; its tail counts as orphan.

Decomposition:
- Shared package flu_length_meter_pkg:
  - Constants BYTES, BLOCK, EOP_POS_WIDTH = log2(BYTES), FIFO_PTR_WIDTH.
  - Saturating add function sat_add(a, b).
- One sub-module, flu_length_meter_fifo: FIFO_ITEMS x LENGTH_WIDTH register FIFO with push/pop/full/empty and registered full.

Test Plan (DATA_WIDTH=256, SOP_POS_WIDTH=2, BLOCK=8):
1. Single word SOP_POS=1, EOP_POS=20 -> one cycle later LENGTH_READY=1, LENGTH=13.
2. Three words: SOP_POS=0; middle; EOP_POS=5 -> LENGTH=70; TX identical to RX every cycle.
3. Frame acc=32, then word EOP_POS=3 with SOP_POS=2, then word EOP_POS=31 -> lengths 36 then 48, in order.
4. 16 single-word frames with LENGTH_NEXT=0 and TX_DST_RDY=1 -> RX_DST_RDY=0 and TX_SRC_RDY=0 on the 17th word. Pulse LENGTH_NEXT -> RX_DST_RDY=1 next cycle; 17th length pushed; first popped LENGTH matches frame 1.
5. RESET mid-frame, then word EOP_POS=9 with no SOP -> word forwarded, LENGTH_READY stays 0; next SOP_POS=0/EOP_POS=31 word -> LENGTH=32.
6. LENGTH_WIDTH=6, four-word frame ending EOP_POS=31 -> LENGTH=63 (saturated). LENGTH_NEXT while empty -> no change.
